// File: rtl/gpu_layer_pkg.sv
// Shared definitions for the layer address sequencer: layer register field map,
// the decoded per-layer view and the sequencer FSM states.
package gpu_layer_pkg;

  localparam int unsigned LR_BITS         = 128;
  localparam int unsigned LR_POPULATED    = 0;
  localparam int unsigned LR_SPRITE       = 1;
  localparam int unsigned LR_VISIBLE      = 2;
  localparam int unsigned LR_RSVD_LO_LSB  = 3;
  localparam int unsigned LR_RSVD_LO_W    = 13;
  localparam int unsigned LR_WIDTH_LSB    = 16;
  localparam int unsigned LR_HEIGHT_LSB   = 32;
  localparam int unsigned LR_XPOS_LSB     = 48;
  localparam int unsigned LR_YPOS_LSB     = 64;
  localparam int unsigned LR_FONTSEL_LSB  = 80;
  localparam int unsigned LR_TEXTLEN_LSB  = 96;
  localparam int unsigned LR_RSVD_HI_LSB  = 112;
  localparam int unsigned LR_RSVD_HI_W    = 8;
  localparam int unsigned LR_FRAME_LSB    = 120;

  // Decoded fields of one layer set; reserved bits are not carried.
  typedef struct packed {
    logic [7:0]  frame;
    logic [15:0] text_length;
    logic [15:0] font_sel;
    logic [15:0] y_pos;
    logic [15:0] x_pos;
    logic [15:0] height;
    logic [15:0] width;
    logic        visible;
    logic        sprite;
    logic        populated;
  } layer_regs_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EVAL = 3'd1,
    ST_DIV  = 3'd2,
    ST_CALC = 3'd3,
    ST_EMIT = 3'd4,
    ST_DONE = 3'd5
  } seq_state_t;

endpackage

// File: rtl/seq_divider_16.sv
// 16-bit restoring divider, one quotient bit per cycle. rdy is high during the
// final iteration cycle; quotient/remainder are valid from the following cycle.
module seq_divider_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        rdy,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);

  logic [15:0] quo_q;
  logic [15:0] rem_q;
  logic [15:0] den_q;
  logic [4:0]  cnt_q;
  logic [16:0] shifted;
  logic [16:0] diff;

  // Partial remainder shifted left with the next dividend bit; borrow means "restore".
  assign shifted = {rem_q, quo_q[15]};
  assign diff    = shifted - {1'b0, den_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      den_q <= divisor;
      cnt_q <= 5'd16;
    end else if (cnt_q != 5'd0) begin
      cnt_q <= cnt_q - 5'd1;
      if (!diff[16]) begin
        rem_q <= diff[15:0];
        quo_q <= {quo_q[14:0], 1'b1};
      end else begin
        rem_q <= shifted[15:0];
        quo_q <= {quo_q[14:0], 1'b0};
      end
    end
  end

  assign rdy       = (cnt_q == 5'd1);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/layer_address_sequencer.sv
// Walks every layer register set for one pixel and streams a RAM byte offset
// (plus a flash bit offset for text layers) for each layer covering the pixel.
// Stream handshake: a result transfers on a cycle where outValid && outReady;
// while outValid is high without outReady, all result outputs hold steady.
module layer_address_sequencer
  import gpu_layer_pkg::*;
#(
  parameter int HOR_PIX         = 480,
  parameter int VER_PIX         = 272,
  parameter int NUM_LAYERS      = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int RAM_ADDR_W      = 27,
  parameter int FLASH_ADDR_W    = 30,
  localparam int X_DEPTH        = $clog2(HOR_PIX),
  localparam int Y_DEPTH        = $clog2(VER_PIX),
  localparam int IDX_W          = $clog2(NUM_LAYERS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [X_DEPTH:0]               xPixel,
  input  logic [Y_DEPTH:0]               yPixel,
  input  logic [NUM_LAYERS*LR_BITS-1:0]  layerRegisters,
  output logic                           busy,
  output logic                           done,
  output logic                           outValid,
  input  logic                           outReady,
  output logic [IDX_W-1:0]               outLayer,
  output logic                           outIsSprite,
  output logic                           outFlashEn,
  output logic [RAM_ADDR_W-1:0]          ramAddressOffsetBytes,
  output logic [FLASH_ADDR_W-1:0]        flashAddressOffsetBits
);

  seq_state_t         state;
  logic [IDX_W-1:0]   idx;
  logic [15:0]        pix_x;
  logic [15:0]        pix_y;
  logic [LR_BITS-1:0] regs_q [NUM_LAYERS];
  logic [LR_BITS-1:0] cur_raw;
  layer_regs_t        cur;
  logic               unused_rsvd;

  logic [15:0] layer_x;
  logic [15:0] layer_y;
  logic [31:0] text_span;
  logic        active;
  logic        sprite_hit;
  logic        text_hit;
  logic        last_layer;

  logic        div_start;
  logic        div_rdy;
  logic [15:0] div_quo;
  logic [15:0] div_rem;

  logic [RAM_ADDR_W-1:0]   spr_ram;
  logic [FLASH_ADDR_W-1:0] txt_flash;

  logic [IDX_W-1:0]        res_layer;
  logic                    res_sprite;
  logic                    res_flash_en;
  logic [RAM_ADDR_W-1:0]   res_ram;
  logic [FLASH_ADDR_W-1:0] res_flash;

  // Snapshot of pixel and all layer sets, taken only when a walk is accepted.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      pix_x <= 16'(xPixel);
      pix_y <= 16'(yPixel);
      for (int i = 0; i < NUM_LAYERS; i++) begin
        regs_q[i] <= layerRegisters[i*LR_BITS +: LR_BITS];
      end
    end
  end

  assign cur_raw = regs_q[idx];

  always_comb begin
    cur             = '0;
    cur.populated   = cur_raw[LR_POPULATED];
    cur.sprite      = cur_raw[LR_SPRITE];
    cur.visible     = cur_raw[LR_VISIBLE];
    cur.width       = cur_raw[LR_WIDTH_LSB   +: 16];
    cur.height      = cur_raw[LR_HEIGHT_LSB  +: 16];
    cur.x_pos       = cur_raw[LR_XPOS_LSB    +: 16];
    cur.y_pos       = cur_raw[LR_YPOS_LSB    +: 16];
    cur.font_sel    = cur_raw[LR_FONTSEL_LSB +: 16];
    cur.text_length = cur_raw[LR_TEXTLEN_LSB +: 16];
    cur.frame       = cur_raw[LR_FRAME_LSB   +: 8];
  end

  assign unused_rsvd = ^{cur_raw[LR_RSVD_LO_LSB +: LR_RSVD_LO_W],
                         cur_raw[LR_RSVD_HI_LSB +: LR_RSVD_HI_W]};

  // 16-bit wrap makes pixels left of / above the layer look far away, so they miss.
  assign layer_x    = pix_x - cur.x_pos;
  assign layer_y    = pix_y - cur.y_pos;
  assign text_span  = 32'(cur.text_length) * 32'(cur.width);
  assign active     = cur.populated && cur.visible;
  assign sprite_hit = active && cur.sprite && (layer_x < cur.width) && (layer_y < cur.height);
  assign text_hit   = active && !cur.sprite && (32'(layer_x) < text_span) && (layer_y < cur.height);
  assign last_layer = (idx == IDX_W'(NUM_LAYERS - 1));
  assign div_start  = (state == ST_EVAL) && text_hit;

  seq_divider_16 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (layer_x),
    .divisor   (cur.width),
    .rdy       (div_rdy),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Computed directly at port width: truncating after each step equals wrapping the full result.
  assign spr_ram = ((RAM_ADDR_W'(cur.frame) * RAM_ADDR_W'(cur.height) + RAM_ADDR_W'(layer_y))
                    * RAM_ADDR_W'(cur.width) + RAM_ADDR_W'(layer_x)) * RAM_ADDR_W'(BYTES_PER_PIXEL);
  assign txt_flash = (FLASH_ADDR_W'(cur.font_sel) * FLASH_ADDR_W'(cur.height) + FLASH_ADDR_W'(layer_y))
                     * FLASH_ADDR_W'(cur.width) + FLASH_ADDR_W'(div_rem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      res_layer    <= '0;
      res_sprite   <= 1'b0;
      res_flash_en <= 1'b0;
      res_ram      <= '0;
      res_flash    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (sprite_hit) begin
            state <= ST_CALC;
          end else if (text_hit) begin
            state <= ST_DIV;
          end else if (last_layer) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_EVAL;
          end
        end
        ST_DIV: begin
          if (div_rdy) state <= ST_CALC;
        end
        ST_CALC: begin
          res_layer  <= idx;
          res_sprite <= cur.sprite;
          if (cur.sprite) begin
            res_ram      <= spr_ram;
            res_flash    <= '0;
            res_flash_en <= 1'b0;
          end else begin
            res_ram      <= RAM_ADDR_W'(div_quo);
            res_flash    <= txt_flash;
            res_flash_en <= 1'b1;
          end
          state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (outReady) begin
            if (last_layer) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_EVAL;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy                   = (state != ST_IDLE);
  assign done                   = (state == ST_DONE);
  assign outValid               = (state == ST_EMIT);
  assign outLayer               = res_layer;
  assign outIsSprite            = res_sprite;
  assign outFlashEn             = res_flash_en;
  assign ramAddressOffsetBytes  = res_ram;
  assign flashAddressOffsetBits = res_flash;

endmodule

// File: tb/tb_layer_address_sequencer.sv
// Directed and randomized pixel walks against a plain-arithmetic reference model.
module tb_layer_address_sequencer;

  localparam int NUM_LAYERS   = 8;
  localparam int IDX_W        = 3;
  localparam int RAM_ADDR_W   = 27;
  localparam int FLASH_ADDR_W = 30;
  localparam int RES_W        = IDX_W + 2 + RAM_ADDR_W + FLASH_ADDR_W;
  localparam int BUDGET       = 3000;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic [9:0]                  xPixel;
  logic [9:0]                  yPixel;
  logic [NUM_LAYERS*128-1:0]   layerRegisters;
  logic                        busy;
  logic                        done;
  logic                        outValid;
  logic                        outReady;
  logic [IDX_W-1:0]            outLayer;
  logic                        outIsSprite;
  logic                        outFlashEn;
  logic [RAM_ADDR_W-1:0]       ramAddressOffsetBytes;
  logic [FLASH_ADDR_W-1:0]     flashAddressOffsetBits;

  typedef struct {
    bit          pop;
    bit          spr;
    bit          vis;
    int unsigned w;
    int unsigned h;
    int unsigned xp;
    int unsigned yp;
    int unsigned fs;
    int unsigned tl;
    int unsigned fr;
  } lay_t;

  lay_t             lay [NUM_LAYERS];
  logic [RES_W-1:0] exp_q [$];
  int               n_assert = 0;
  int               n_fail   = 0;

  int               fv, dc, got;
  logic [RES_W-1:0] last_res;

  layer_address_sequencer dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .xPixel                 (xPixel),
    .yPixel                 (yPixel),
    .layerRegisters         (layerRegisters),
    .busy                   (busy),
    .done                   (done),
    .outValid               (outValid),
    .outReady               (outReady),
    .outLayer               (outLayer),
    .outIsSprite            (outIsSprite),
    .outFlashEn             (outFlashEn),
    .ramAddressOffsetBytes  (ramAddressOffsetBytes),
    .flashAddressOffsetBits (flashAddressOffsetBits)
  );

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_layers();
    for (int i = 0; i < NUM_LAYERS; i++) lay[i] = '{default: 0};
  endtask

  task automatic apply_layers(input bit junk);
    logic [127:0] v;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      v = '0;
      if (junk) begin
        v[15:3]    = 13'($urandom);
        v[119:112] = 8'($urandom);
      end
      v[0]       = lay[i].pop;
      v[1]       = lay[i].spr;
      v[2]       = lay[i].vis;
      v[31:16]   = 16'(lay[i].w);
      v[47:32]   = 16'(lay[i].h);
      v[63:48]   = 16'(lay[i].xp);
      v[79:64]   = 16'(lay[i].yp);
      v[95:80]   = 16'(lay[i].fs);
      v[111:96]  = 16'(lay[i].tl);
      v[127:120] = 8'(lay[i].fr);
      layerRegisters[i*128 +: 128] = v;
    end
  endtask

  // Reference: every covering layer in index order yields one result.
  task automatic model(input int unsigned x, input int unsigned y);
    longint unsigned lx, ly, ram, flash;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      lx = longint'((x - lay[i].xp) & 32'hFFFF);
      ly = longint'((y - lay[i].yp) & 32'hFFFF);
      if (lay[i].pop && lay[i].vis && ly < lay[i].h) begin
        if (lay[i].spr && lx < lay[i].w) begin
          ram = ((longint'(lay[i].fr) * lay[i].h + ly) * lay[i].w + lx) * 2;
          exp_q.push_back({IDX_W'(i), 1'b1, 1'b0, RAM_ADDR_W'(ram), FLASH_ADDR_W'(0)});
        end else if (!lay[i].spr && lx < longint'(lay[i].tl) * lay[i].w) begin
          ram   = lx / lay[i].w;
          flash = (longint'(lay[i].fs) * lay[i].h + ly) * lay[i].w + (lx % lay[i].w);
          exp_q.push_back({IDX_W'(i), 1'b0, 1'b1, RAM_ADDR_W'(ram), FLASH_ADDR_W'(flash)});
        end
      end
    end
  endtask

  // ---------------- driver + scoreboard ----------------
  task automatic run_walk(input int x, input int y, input int hold, input bit rnd_ready,
                          input bit poke_start, input bit junk,
                          output int first_valid, output int done_cyc, output int n_got,
                          output logic [RES_W-1:0] last);
    int cyc;
    exp_q.delete();
    model(x, y);
    apply_layers(junk);
    @(posedge clk); #1;
    xPixel = 10'(x); yPixel = 10'(y); start = 1'b1; outReady = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; first_valid = -1; done_cyc = -1; n_got = 0; last = '0;
    while (cyc < BUDGET) begin
      outReady = (cyc >= hold) && (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (poke_start) start = 1'($urandom_range(0, 1));
      check("busy_during_walk", busy, 1);
      if (outValid) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", outValid, 0);
        end else begin
          check("result", {outLayer, outIsSprite, outFlashEn, ramAddressOffsetBytes,
                           flashAddressOffsetBits}, exp_q[0]);
          if (outReady) begin
            last = exp_q.pop_front();
            n_got++;
          end
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; outReady = 1'b0;
    check("walk_within_budget", (cyc < BUDGET), 1);
    check("results_outstanding", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  function automatic lay_t sprite0();
    lay_t l = '{default: 0};
    l.pop = 1; l.spr = 1; l.vis = 1; l.xp = 10; l.yp = 20; l.w = 32; l.h = 16; l.fr = 2;
    return l;
  endfunction

  function automatic lay_t text1();
    lay_t l = '{default: 0};
    l.pop = 1; l.spr = 0; l.vis = 1; l.xp = 100; l.yp = 50; l.w = 8; l.h = 12; l.tl = 4; l.fs = 3;
    return l;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    int x, y;
    rst = 1'b1; start = 1'b0; xPixel = '0; yPixel = '0; outReady = 1'b0;
    layerRegisters = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", outValid, 0);
    check("rst_result", {outLayer, outIsSprite, outFlashEn, ramAddressOffsetBytes,
                         flashAddressOffsetBits}, 0);
    rst = 1'b0;

    // Sprite hit in layer 0: EVAL, CALC, EMIT -> valid on third cycle after start edge.
    clear_layers();
    lay[0] = sprite0();
    run_walk(15, 25, 0, 0, 0, 0, fv, dc, got, last_res);
    check("sprite_first_valid", fv, 2);
    check("sprite_ram", last_res[FLASH_ADDR_W +: RAM_ADDR_W], 2378);
    check("sprite_count", got, 1);
    check("sprite_done_cyc", dc, 10);

    // Text hit in layer 1 after a layer-0 miss: 1 + 18 cycles.
    clear_layers();
    lay[1] = text1();
    run_walk(119, 53, 0, 0, 0, 0, fv, dc, got, last_res);
    check("text_first_valid", fv, 19);
    check("text_ram", last_res[FLASH_ADDR_W +: RAM_ADDR_W], 2);
    check("text_flash", last_res[FLASH_ADDR_W-1:0], 315);
    check("text_flash_en", last_res[FLASH_ADDR_W + RAM_ADDR_W], 1);
    check("text_done_cyc", dc, 26);

    // Pixel left/above the layer: wrap-around miss, done NUM_LAYERS+1 cycles after start cycle.
    clear_layers();
    lay[0] = sprite0();
    run_walk(5, 5, 0, 0, 0, 0, fv, dc, got, last_res);
    check("miss_no_valid", fv, -1);
    check("miss_done_latency", dc + 1, NUM_LAYERS + 1);

    // Back-pressure with sprite in 0 and text in 1; start pokes while busy.
    clear_layers();
    lay[0] = sprite0();
    lay[1] = text1();
    lay[1].xp = 0; lay[1].yp = 20; lay[1].tl = 6;
    run_walk(15, 25, 10, 0, 1, 0, fv, dc, got, last_res);
    check("bp_first_valid", fv, 2);
    check("bp_count", got, 2);
    check("bp_last_layer", last_res[RES_W-1 -: IDX_W], 1);

    // Reset during the text divide.
    clear_layers();
    lay[1] = text1();
    apply_layers(0);
    @(posedge clk); #1;
    xPixel = 10'd119; yPixel = 10'd53; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", outValid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", {outLayer, outIsSprite, outFlashEn, ramAddressOffsetBytes,
                             flashAddressOffsetBits}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("no_activity_after_reset", dones, 0);
    clear_layers();
    lay[0] = sprite0();
    run_walk(15, 25, 0, 0, 0, 0, fv, dc, got, last_res);
    check("post_rst_first_valid", fv, 2);
    check("post_rst_ram", last_res[FLASH_ADDR_W +: RAM_ADDR_W], 2378);

    // Populated but invisible sprite covering the pixel.
    clear_layers();
    lay[0] = sprite0();
    lay[0].vis = 0;
    run_walk(15, 25, 0, 0, 0, 0, fv, dc, got, last_res);
    check("invisible_count", got, 0);
    check("invisible_no_valid", fv, -1);

    // Randomized walks.
    for (int t = 0; t < 25; t++) begin
      x = $urandom_range(0, 479);
      y = $urandom_range(0, 271);
      for (int i = 0; i < NUM_LAYERS; i++) begin
        lay[i].pop = ($urandom_range(0, 4) != 0);
        lay[i].vis = ($urandom_range(0, 4) != 0);
        lay[i].spr = 1'($urandom_range(0, 1));
        lay[i].w   = $urandom_range(0, 40);
        lay[i].h   = $urandom_range(0, 20);
        lay[i].tl  = $urandom_range(0, 8);
        lay[i].fs  = $urandom_range(0, 65535);
        lay[i].fr  = $urandom_range(0, 255);
        if ($urandom_range(0, 3) == 0) lay[i].xp = x + $urandom_range(1, 20);
        else                           lay[i].xp = (x - $urandom_range(0, 40)) & 32'hFFFF;
        if ($urandom_range(0, 3) == 0) lay[i].yp = y + $urandom_range(1, 20);
        else                           lay[i].yp = (y - $urandom_range(0, 20)) & 32'hFFFF;
      end
      run_walk(x, y, $urandom_range(0, 5), 1, 1, 1, fv, dc, got, last_res);
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_address_sequencer.md
Name: layer_address_sequencer

Overview:
Multi-layer successor to the single-layer address calculation unit.
- For one screen pixel, it walks all NUM_LAYERS layer register sets in index order.
- For each layer that covers the pixel, it computes the RAM byte offset and, for text layers, the flash bit offset.
- It emits one result per hit layer on a valid/ready stream to the fetch stage.
- It sits between the pixel scanner and the RAM/flash fetch units of the GPU ALU pipe.

Parameters:
HOR_PIX, 480, screen width in pixels; X_DEPTH = $clog2(HOR_PIX)
VER_PIX, 272, screen height in pixels; Y_DEPTH = $clog2(VER_PIX)
NUM_LAYERS, 8, number of layer register sets; IDX_W = $clog2(NUM_LAYERS)
BYTES_PER_PIXEL, 2, sprite RAM bytes per pixel
RAM_ADDR_W, 27, RAM byte-offset width
FLASH_ADDR_W, 30, flash bit-offset width

Ports:
clk  in  1  system clock, 50 MHz max
rst  in  1  reset, asynchronous and active-high
start  in  1  starts a pixel walk; accepted only in IDLE
xPixel  in  X_DEPTH+1  pixel x, sampled on accepted start
yPixel  in  Y_DEPTH+1  pixel y, sampled on accepted start
layerRegisters  in  NUM_LAYERS*128  layer i occupies bits [128*i+127:128*i], sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the walk completes
outValid  out  1  result valid
outReady  in  1  consumer accepts the result
outLayer  out  IDX_W  index of the result's layer
outIsSprite  out  1  layer type of the result
outFlashEn  out  1  flash offset is meaningful (text layers)
ramAddressOffsetBytes  out  RAM_ADDR_W  RAM offset
flashAddressOffsetBits  out  FLASH_ADDR_W  flash offset

Behaviour:
- Layer field map (per 128-bit set):
  - [0] populated; [1] sprite(1)/text(0); [2] visible
  - [31:16] width (sprite width or font width); [47:32] height
  - [63:48] xPos; [79:64] yPos; [95:80] fontSel; [111:96] textLength; [127:120] frame
- Reset values: all outputs 0; FSM in IDLE; layer counter 0.
- Reset mid-walk aborts immediately. No done pulse is produced.
- FSM states: IDLE, EVAL, DIV, CALC, EMIT, DONE.
  - IDLE: on start, latch pixel and all registers, set i=0, go to EVAL. start is ignored in every other state.
  - EVAL (1 cycle):
    - layerX = x - xPos and layerY = y - yPos, both 16-bit unsigned with wrap-around, so a pixel left of/above the layer never hits.
    - active = populated && visible.
    - Sprite hit = active && layerX<width && layerY<height. Hit goes to CALC.
    - Text hit = active && layerX < textLength*width (32-bit product) && layerY<height. Hit goes to DIV.
    - A miss advances i: go to EVAL, or to DONE if i==NUM_LAYERS-1.
  - DIV: start divider with layerX/width and wait for its rdy, exactly 16 cycles. Quotient is charIdx; remainder is col.
  - CALC (1 cycle), register the result:
    - Sprite: ram = ((frame*height + layerY)*width + layerX)*BYTES_PER_PIXEL; flash = 0; flashEn = 0.
    - Text: ram = charIdx; flash = ((fontSel*height + layerY)*width + col); flashEn = 1.
    - Results are truncated to the port widths (wrap, no saturation).
  - EMIT: outValid=1 and all result outputs are held stable. On outValid && outReady, advance as in a miss. Back-pressure holds indefinitely.
  - DONE: done=1 for one cycle, then IDLE.
- busy = (state != IDLE).
- Latency per layer:
  - miss: 1 cycle
  - sprite: 3 cycles to first outValid-capable cycle (EVAL, CALC, EMIT)
  - text: 19 cycles
- A walk with no hits produces done exactly NUM_LAYERS+1 cycles after start.
- width=0 never hits, so the divider never sees a zero divisor.

Decomposition:
- Package gpu_layer_pkg holds:
  - field bit-position localparams
  - a packed layer_regs_t struct
  - the FSM state enum
- One sub-module: seq_divider_16 (16-bit restoring divider, 1 bit per cycle, start/rdy, quotient/remainder).
- Multipliers stay inline in CALC.

Test Plan:
- Sprite hit: layer0 = {pop=1, sprite=1, vis=1, xPos=10, yPos=20, width=32, height=16, frame=2}, pixel (15,25) -> one result: outLayer=0, ram=2378, flashEn=0, followed by done.
- Text hit: layer1 = {pop=1, sprite=0, vis=1, xPos=100, yPos=50, width=8, height=12, textLength=4, fontSel=3}, others vacant, pixel (119,53) -> ram=2, flash=315, flashEn=1, outValid 19 cycles after EVAL of layer1.
- Misses: pixel (5,5) against layer0 above (xPos=10) -> wrap makes layerX=65531 -> no outValid; done exactly NUM_LAYERS+1 cycles after start.
- Back-pressure: sprite and text hits in layers 0 and 1, outReady low 10 cycles -> outputs stable while held; results appear in order 0 then 1; start pulses while busy ignored.
- Reset mid-DIV: assert rst during text divide -> all outputs 0 immediately, no done; next start behaves normally.
- Invisible/vacant: populated=1, visible=0 sprite covering the pixel -> no result emitted.
